// File: rtl/reset_sequencer_if.sv
// Bundles the staged-reset control and status signals between the sequencer
// and the blocks it releases. The sequencer is the master: it drives the reset
// lines and status, and receives readiness and soft-restart requests.
interface reset_sequencer_if #(
   parameter int STAGES = 4
);
   localparam int FSW = $clog2(STAGES);

   logic              soft_reset_req;
   logic [STAGES-1:0] stage_ready;
   logic [STAGES-1:0] stage_reset;
   logic              done;
   logic              fault;
   logic [FSW-1:0]    fault_stage;

   modport master (
      input  soft_reset_req,
      input  stage_ready,
      output stage_reset,
      output done,
      output fault,
      output fault_stage
   );

   modport slave (
      output soft_reset_req,
      output stage_ready,
      input  stage_reset,
      input  done,
      input  fault,
      input  fault_stage
   );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset release: stage lines drop one at a time, GAP edges after the previous stage acks.
// Latency: stage 0 releases GAP edges after reset; each later stage GAP edges after the prior ack.
// No backpressure: a stage that never acks within TIMEOUT edges leaves a sticky fault.
module reset_sequencer #(
   parameter int STAGES  = 4,
   parameter int GAP     = 8,
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               reset_n,
   reset_sequencer_if.master sq
);
   localparam int CMAX = (GAP > TIMEOUT) ? GAP : TIMEOUT;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int IW   = $clog2(STAGES);

   localparam logic [IW-1:0] LAST   = IW'(STAGES - 1);
   localparam logic [CW-1:0] GAP_LD = CW'(GAP);
   localparam logic [CW-1:0] TO_LD  = CW'(TIMEOUT);
   localparam logic [CW-1:0] ONE    = CW'(1);

   typedef enum logic [1:0] {
      S_HOLD,
      S_WAIT,
      S_DONE,
      S_FAULT
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   // Shared down-counter: counts the hold gap in HOLD, the ack window in WAIT.
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [STAGES-1:0] stage_reset_q, stage_reset_d;
   logic              done_q, done_d;
   logic              fault_q, fault_d;
   logic [IW-1:0]     fault_stage_q, fault_stage_d;

   // State and output registers; asynchronous reset holds every stage in reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_HOLD;
         idx_q         <= '0;
         cnt_q         <= GAP_LD;
         stage_reset_q <= '1;
         done_q        <= 1'b0;
         fault_q       <= 1'b0;
         fault_stage_q <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         stage_reset_q <= stage_reset_d;
         done_q        <= done_d;
         fault_q       <= fault_d;
         fault_stage_q <= fault_stage_d;
      end
   end

   // Next-state logic; soft restart overrides release, ack and timeout on the same edge.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      stage_reset_d = stage_reset_q;
      done_d        = done_q;
      fault_d       = fault_q;
      fault_stage_d = fault_stage_q;

      if (sq.soft_reset_req) begin
         state_d       = S_HOLD;
         idx_d         = '0;
         cnt_d         = GAP_LD;
         stage_reset_d = '1;
         done_d        = 1'b0;
         fault_d       = 1'b0;
         fault_stage_d = '0;
      end else begin
         case (state_q)
            S_HOLD: begin
               cnt_d = cnt_q - ONE;
               if (cnt_q == ONE) begin
                  stage_reset_d[idx_q] = 1'b0;
                  cnt_d                = TO_LD;
                  state_d              = S_WAIT;
               end
            end
            S_WAIT: begin
               if (sq.stage_ready[idx_q]) begin
                  if (idx_q == LAST) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     cnt_d   = GAP_LD;
                     state_d = S_HOLD;
                  end
               end else if (TIMEOUT != 0) begin
                  cnt_d = cnt_q - ONE;
                  if (cnt_q == ONE) begin
                     // Put the stuck stage back into reset; earlier stages stay released.
                     stage_reset_d[idx_q] = 1'b1;
                     fault_d              = 1'b1;
                     fault_stage_d        = idx_q;
                     done_d               = 1'b0;
                     state_d              = S_FAULT;
                  end
               end
            end
            S_DONE:  ;
            S_FAULT: ;
            default: state_d = S_HOLD;
         endcase
      end
   end

   assign sq.stage_reset = stage_reset_q;
   assign sq.done        = done_q;
   assign sq.fault       = fault_q;
   assign sq.fault_stage = fault_stage_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: nominal release, late ack, soft restarts,
// timeout boundary and fault hold, asynchronous reset with the clock stopped,
// and a second instance with the timeout disabled.
module tb_reset_sequencer;
   logic clk     = 1'b0;
   logic clk_run = 1'b1;
   logic reset_n;
   int   edge_n;
   int   n_chk  = 0;
   int   n_pass = 0;
   logic saw_fault_a, saw_fault_b;

   reset_sequencer_if #(.STAGES(4)) ifa ();
   reset_sequencer_if #(.STAGES(4)) ifb ();

   reset_sequencer #(.STAGES(4), .GAP(8), .TIMEOUT(255)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .sq      (ifa)
   );

   reset_sequencer #(.STAGES(4), .GAP(8), .TIMEOUT(0)) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .sq      (ifb)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
      if (ifa.fault) saw_fault_a = 1'b1;
      if (ifb.fault) saw_fault_b = 1'b1;
   endtask

   task automatic run_to(input int e);
      while (edge_n < e) tick();
   endtask

   task automatic pulse_a();
      ifa.soft_reset_req = 1'b1;
      tick();
      ifa.soft_reset_req = 1'b0;
      edge_n = 0;
   endtask

   task automatic pulse_b();
      ifb.soft_reset_req = 1'b1;
      tick();
      ifb.soft_reset_req = 1'b0;
      edge_n = 0;
   endtask

   initial begin
      reset_n            = 1'b0;
      ifa.soft_reset_req = 1'b0;
      ifa.stage_ready    = 4'b1111;
      ifb.soft_reset_req = 1'b0;
      ifb.stage_ready    = 4'b0000;
      edge_n             = 0;
      saw_fault_a        = 1'b0;
      saw_fault_b        = 1'b0;

      // Reset values while reset_n is low
      #12;
      chk("rst_sr",    32'(ifa.stage_reset), 'hF);
      chk("rst_done",  32'(ifa.done), 0);
      chk("rst_fault", 32'(ifa.fault), 0);
      chk("rst_fst",   32'(ifa.fault_stage), 0);
      @(negedge clk);
      reset_n = 1'b1;
      edge_n  = 0;

      // Nominal: releases at 8, 17, 26, 35; done at 36
      run_to(7);  chk("nom_sr7",  32'(ifa.stage_reset), 'hF);
      run_to(8);  chk("nom_sr8",  32'(ifa.stage_reset), 'hE);
      run_to(16); chk("nom_sr16", 32'(ifa.stage_reset), 'hE);
      run_to(17); chk("nom_sr17", 32'(ifa.stage_reset), 'hC);
      run_to(25); chk("nom_sr25", 32'(ifa.stage_reset), 'hC);
      run_to(26); chk("nom_sr26", 32'(ifa.stage_reset), 'h8);
      run_to(34); chk("nom_sr34", 32'(ifa.stage_reset), 'h8);
      run_to(35); chk("nom_sr35", 32'(ifa.stage_reset), 'h0);
      chk("nom_done35", 32'(ifa.done), 0);
      run_to(36); chk("nom_done36", 32'(ifa.done), 1);
      chk("nom_nofault", 32'(saw_fault_a), 0);
      run_to(46); chk("nom_done_hold", 32'(ifa.done), 1);

      // Soft restart from DONE, then late ack on stage 2 at edge 46
      ifa.stage_ready = 4'b1011;
      pulse_a();
      chk("sdone_sr",   32'(ifa.stage_reset), 'hF);
      chk("sdone_done", 32'(ifa.done), 0);
      run_to(26); chk("late_sr26", 32'(ifa.stage_reset), 'h8);
      run_to(45); chk("late_sr45", 32'(ifa.stage_reset), 'h8);
      ifa.stage_ready = 4'b1111;
      run_to(46); chk("late_sr46", 32'(ifa.stage_reset), 'h8);
      run_to(53); chk("late_sr53", 32'(ifa.stage_reset), 'h8);
      run_to(54); chk("late_sr54", 32'(ifa.stage_reset), 'h0);
      chk("late_done54", 32'(ifa.done), 0);
      run_to(55); chk("late_done55", 32'(ifa.done), 1);

      // Soft restart while stage 2 waits
      ifa.stage_ready = 4'b1011;
      pulse_a();
      run_to(30); chk("swait_pre", 32'(ifa.stage_reset), 'h8);
      ifa.stage_ready = 4'b1111;
      pulse_a();
      chk("swait_sr", 32'(ifa.stage_reset), 'hF);
      run_to(7); chk("swait_sr7", 32'(ifa.stage_reset), 'hF);
      run_to(8); chk("swait_sr8", 32'(ifa.stage_reset), 'hE);

      // Ack on the last edge of the window beats the timeout
      ifa.stage_ready = 4'b1101;
      pulse_a();
      saw_fault_a = 1'b0;
      run_to(271); chk("edge_sr271", 32'(ifa.stage_reset), 'hC);
      ifa.stage_ready = 4'b1111;
      run_to(272); chk("edge_fault272", 32'(ifa.fault), 0);
      run_to(280); chk("edge_sr280", 32'(ifa.stage_reset), 'h8);
      chk("edge_nofault", 32'(saw_fault_a), 0);

      // Timeout on stage 1 at edge 272, held for 100 more edges
      ifa.stage_ready = 4'b1101;
      pulse_a();
      run_to(271);
      chk("to_fault271", 32'(ifa.fault), 0);
      chk("to_sr271",    32'(ifa.stage_reset), 'hC);
      run_to(272);
      chk("to_fault",    32'(ifa.fault), 1);
      chk("to_fst",      32'(ifa.fault_stage), 1);
      chk("to_sr",       32'(ifa.stage_reset), 'hE);
      chk("to_done",     32'(ifa.done), 0);
      ifa.stage_ready = 4'b1111;
      run_to(372);
      chk("hold_fault",  32'(ifa.fault), 1);
      chk("hold_fst",    32'(ifa.fault_stage), 1);
      chk("hold_sr",     32'(ifa.stage_reset), 'hE);
      chk("hold_done",   32'(ifa.done), 0);

      // Soft restart from FAULT
      pulse_a();
      chk("sflt_fault", 32'(ifa.fault), 0);
      chk("sflt_fst",   32'(ifa.fault_stage), 0);
      chk("sflt_sr",    32'(ifa.stage_reset), 'hF);
      chk("sflt_done",  32'(ifa.done), 0);

      // Asynchronous reset mid-HOLD with the clock stopped
      run_to(12); chk("async_pre", 32'(ifa.stage_reset), 'hE);
      @(negedge clk);
      clk_run = 1'b0;
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_sr",    32'(ifa.stage_reset), 'hF);
      chk("async_done",  32'(ifa.done), 0);
      chk("async_fault", 32'(ifa.fault), 0);
      #10;
      reset_n = 1'b1;
      #3;
      edge_n  = 0;
      clk_run = 1'b1;
      run_to(7);  chk("arel_sr7",  32'(ifa.stage_reset), 'hF);
      run_to(8);  chk("arel_sr8",  32'(ifa.stage_reset), 'hE);
      run_to(35); chk("arel_sr35", 32'(ifa.stage_reset), 'h0);
      run_to(36); chk("arel_done", 32'(ifa.done), 1);

      // Timeout disabled: stage 0 waits indefinitely, ack at 1008 releases stage 1 at 1016
      ifb.stage_ready = 4'b0000;
      pulse_b();
      saw_fault_b = 1'b0;
      run_to(7);    chk("nto_sr7",    32'(ifb.stage_reset), 'hF);
      run_to(8);    chk("nto_sr8",    32'(ifb.stage_reset), 'hE);
      run_to(1007); chk("nto_sr1007", 32'(ifb.stage_reset), 'hE);
      chk("nto_nofault", 32'(saw_fault_b), 0);
      ifb.stage_ready = 4'b0001;
      run_to(1015); chk("nto_sr1015", 32'(ifb.stage_reset), 'hE);
      run_to(1016); chk("nto_sr1016", 32'(ifb.stage_reset), 'hC);
      chk("nto_fault", 32'(ifb.fault), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
